// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-save multiplier: FSM states, the
// carry-save row width and a constant function sizing the partial-product counter.
package csa_pkg;

    localparam int unsigned ROW_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        RESOLVE,
        DONE
    } state_e;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/csa_seq_mult_if.sv
// Operand/result handshake bundle for csa_seq_mult. The master side supplies
// operands and consumes the product; the slave side is the multiplier.
interface csa_seq_mult_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );

endinterface

// File: rtl/csa_row_64.sv
// One 64-bit row of 3:2 carry-save compressors. U is the bitwise sum, V is the
// majority shifted left by one; the carry out of bit 63 is dropped on purpose
// because the accumulated product never exceeds 64 bits.
module csa_row_64
    import csa_pkg::*;
(
    input  logic [ROW_W-1:0] x_i,
    input  logic [ROW_W-1:0] y_i,
    input  logic [ROW_W-1:0] z_i,
    output logic [ROW_W-1:0] u_o,
    output logic [ROW_W-1:0] v_o
);

    logic [ROW_W-2:0] maj;

    // Full-adder sum and carry per bit position.
    always_comb begin
        u_o = x_i ^ y_i ^ z_i;
        maj = (x_i[ROW_W-2:0] & y_i[ROW_W-2:0])
            | (x_i[ROW_W-2:0] & z_i[ROW_W-2:0])
            | (y_i[ROW_W-2:0] & z_i[ROW_W-2:0]);
        v_o = {maj, 1'b0};
    end

endmodule

// File: rtl/csa_seq_mult.sv
// Iterative multiplier: one partial product per cycle through a single 64-bit
// carry-save row, then one carry-propagate add. Latency is WIDTH+2 cycles from
// accept to out_valid, regardless of operand values.
// Optional build macro CSA_SEQ_SIGNED_EN selects two's complement operands
// (sign-extended multiplicand, inverted last partial product, carry-in of b's
// sign bit); without it the block is unsigned only.
module csa_seq_mult
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    csa_seq_mult_if.slave    bus
);

    localparam int unsigned      CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [ROW_W-1:0]     sum_q, sum_d;
    logic [ROW_W-1:0]     carry_q, carry_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [ROW_W-1:0]     a_ext;
    logic [ROW_W-1:0]     shifted;
    logic [ROW_W-1:0]     pp;
    logic [ROW_W-1:0]     row_u;
    logic [ROW_W-1:0]     row_v;
    logic                 cin;
    logic [ROW_W-1:0]     resolved;

`ifdef CSA_SEQ_SIGNED_EN
    assign a_ext = {{(ROW_W - WIDTH){a_q[WIDTH-1]}}, a_q};
    // Adds the +1 that completes negating the inverted last partial product.
    assign cin   = b_q[WIDTH-1];
`else
    assign a_ext = {{(ROW_W - WIDTH){1'b0}}, a_q};
    assign cin   = 1'b0;
`endif

    // Partial-product select for the current multiplier bit.
    always_comb begin
        shifted = a_ext << cnt_q;
        pp      = '0;
        if (b_q[cnt_q]) begin
`ifdef CSA_SEQ_SIGNED_EN
            if (cnt_q == LAST_CNT) begin
                pp = ~shifted;
            end else begin
                pp = shifted;
            end
`else
            pp = shifted;
`endif
        end
    end

    csa_row_64 u_row (
        .x_i (sum_q),
        .y_i (carry_q),
        .z_i (pp),
        .u_o (row_u),
        .v_o (row_v)
    );

    // Final carry-propagate add of the redundant accumulator.
    assign resolved = sum_q + carry_q + ROW_W'(cin);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                // in_ready_q is low in the first cycle out of reset, so gate on it.
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                sum_d   = row_u;
                carry_d = row_v;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                product_d = resolved[2*WIDTH-1:0];
                state_d   = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == REDUCE) || (state_d == RESOLVE);
    end

    // All state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_csa_seq_mult.sv
// Scoreboard bench for csa_seq_mult (WIDTH=32). Expected products are pushed
// when operands are driven and popped when the DUT presents a result.
module tb_csa_seq_mult;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;

    csa_seq_mult_if #(.WIDTH(WIDTH)) bus ();

    csa_seq_mult #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] sb[$];

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef CSA_SEQ_SIGNED_EN
        logic signed [63:0] sa;
        logic signed [63:0] sb_v;
        sa   = {{32{a[31]}}, a};
        sb_v = {{32{b[31]}}, b};
        return sa * sb_v;
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    // One transaction: bp_cycles of backpressure, optional stray in_valid pulse
    // during REDUCE, optional reset when cnt reaches rst_at (-1 = none).
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input int bp_cycles, input bit pulse, input int rst_at);
        int lat;
        int guard;
        logic [63:0] exp_p;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = op_a;
        bus.b        = op_b;
        sb.push_back(model(op_a, op_b));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        lat = 1;
        check_val("busy_reduce", bus.busy, 1);
        check_val("in_ready_busy", bus.in_ready, 0);
        while (!bus.out_valid && lat < 100) begin
            if (rst_at >= 0 && lat == rst_at + 1) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                sb.delete();
                check_val("rst_in_ready", bus.in_ready, 0);
                check_val("rst_out_valid", bus.out_valid, 0);
                check_val("rst_busy", bus.busy, 0);
                check_val("rst_product", bus.product, 0);
                @(negedge clk);
                check_val("rst_in_ready_after", bus.in_ready, 1);
                check_val("rst_out_valid_after", bus.out_valid, 0);
                return;
            end
            if (pulse && lat == 5) begin
                bus.in_valid = 1'b1;
                bus.a        = 32'd7;
                bus.b        = 32'd9;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check_val("latency", lat, WIDTH + 2);
        check_val("sb_size", sb.size(), 1);
        exp_p = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        check_val("product", bus.product, exp_p);
        check_val("busy_done", bus.busy, 0);
        for (int i = 0; i < bp_cycles; i++) begin
            @(negedge clk);
            check_val("bp_out_valid", bus.out_valid, 1);
            check_val("bp_product", bus.product, exp_p);
            check_val("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("post_out_valid", bus.out_valid, 0);
        check_val("post_in_ready", bus.in_ready, 1);
        check_val("post_product", bus.product, exp_p);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_in_ready", bus.in_ready, 0);
        check_val("reset_out_valid", bus.out_valid, 0);
        check_val("reset_busy", bus.busy, 0);
        check_val("reset_product", bus.product, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("first_in_ready", bus.in_ready, 1);

        run_op(32'd3, 32'd5, 0, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, -1);
        run_op(32'h0, 32'hFFFF_FFFF, 0, 1'b0, -1);
        run_op(32'h8000_0000, 32'd2, 0, 1'b0, -1);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0, -1);
        run_op(32'd6, 32'd4, 0, 1'b1, -1);
        run_op(32'hDEAD_BEEF, 32'h0000_1234, 0, 1'b0, 10);
        run_op(32'd2, 32'd3, 0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, i, 1'b0, -1);
        end
        check_val("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/csa_seq_mult.md
# csa_seq_mult

Iterative multi-cycle multiplier built around a single 64-bit carry-save row. It sits beside the Wallace-tree datapath as its low-area alternative. It accepts two WIDTH-bit operands and feeds one partial product per cycle into the 3:2 compressor, accumulating in redundant sum/carry form. A single carry-propagate add then resolves the 2*WIDTH-bit product, returned over a valid/ready handshake.

## Interface
- WIDTH, 32, operand width; legal range 2..32, so the product fits the 64-bit row.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- in_valid  input  1  operands present.
- in_ready  output  1  block idle and able to accept.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product held valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result; only the low 2*WIDTH bits of the 64-bit accumulation are used.
- busy  output  1  high in REDUCE or RESOLVE.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch a and b, clear sum/carry to 0, clear cnt to 0, go to REDUCE.
  - REDUCE: each cycle, pp = b_reg[cnt] ? (ext(a_reg) << cnt) : 0, all 64 bits. Then {sum,carry} <= row(sum, carry, pp) and cnt <= cnt+1. After the cycle with cnt==WIDTH-1, go to RESOLVE.
  - RESOLVE: product_reg <= sum + carry + cin, modulo 2^64, truncated to 2*WIDTH. Go to DONE.
  - DONE: out_valid=1 and product stable. On out_ready, go to IDLE.
- ext() is zero-extension to 64 bits; cin=0 (unsigned build).
- in_valid outside IDLE is ignored. No queuing; operands are never overwritten mid-operation.
- The row computes U = X^Y^Z and V = maj(X,Y,Z)<<1 with V[0]=0. The carry out of bit 63 is discarded; this is harmless because the product is at most 64 bits.
- Operands of zero still take the full latency; there is no early termination.

## Timing
- Reset values: in_ready=0 during reset and 1 from the first cycle after reset; out_valid=0; busy=0; product=0; state=IDLE; cnt=0.
- Accept edge is T0, where in_valid && in_ready.
- REDUCE occupies cycles T0+1 .. T0+WIDTH. RESOLVE is cycle T0+WIDTH+1.
- out_valid rises WIDTH+2 cycles after T0, i.e. 34 cycles for WIDTH=32.
- Handshake completes on the edge where out_valid && out_ready. The block is in IDLE and in_ready=1 on the next cycle.
- Minimum issue interval is WIDTH+3 cycles. No accept occurs in the same cycle as output completion.
- Backpressure: out_ready low holds DONE indefinitely, with product unchanged.
- Reset asserted in any state forces the reset values on the next edge and abandons any in-flight operation; no partial result is emitted.
- product changes only on the RESOLVE edge or on reset.

## Configuration
- CSA_SEQ_SIGNED_EN defined: operands are two's complement.
  - ext() becomes sign-extension of a to 64 bits.
  - For cnt==WIDTH-1 with b_reg[WIDTH-1]=1, pp = ~(ext(a_reg) << (WIDTH-1)).
  - cin = b_reg[WIDTH-1] in RESOLVE.
  - product is the signed 2*WIDTH-bit result.
- CSA_SEQ_SIGNED_EN undefined: unsigned only; cin is tied to 0 and no inversion logic is present.
- Latency is identical in both builds.

## Structure
- Shared package csa_pkg holds:
  - the FSM state enum {IDLE, REDUCE, RESOLVE, DONE};
  - ROW_W=64;
  - the counter width function clog2(WIDTH).
- One sub-module, csa_row_64: a purely combinational 64-bit 3:2 compressor (X,Y,Z to U,V) as defined above, instantiated once.
- The top level holds the FSM, operand registers, sum/carry registers, cnt, the partial-product mux and the final adder.

## Test plan
- Unsigned, a=3, b=5 -> product=15, with out_valid exactly 34 cycles after accept (WIDTH=32).
- Unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; also a=0, b=0xFFFFFFFF -> 0 with full latency.
- Signed build, a=0xFFFFFFFF (-1), b=0xFFFFFFFF (-1) -> product=1; a=0x80000000, b=2 -> 0xFFFFFFFF00000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product and out_valid stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle.
- in_valid pulsed with a=7, b=9 during REDUCE of 6*4 -> product=24; the second operand pair is not latched.
- rst_n low for one cycle at REDUCE cnt=10 -> all outputs at reset values next cycle. A following 2*3 -> 6 with normal latency.
